// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size codes, sequencer states,
// and helpers that turn a size code into a byte count and an alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Number of single-byte memory accesses for a size code; 0 marks an illegal size.
  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of an assembled little-endian load word
// according to the access size.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  size_e           size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    ext = word;
    case (size)
      SZ_BYTE: ext = {{(XLEN-8){~is_unsigned & word[7]}}, word[7:0]};
      SZ_HALF: ext = {{(XLEN-16){~is_unsigned & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: one byte/half/word request becomes 1/2/4 byte accesses,
// little-endian, one per clock. Define MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = 1;

  state_e          state_q;
  size_e           size_q;
  logic            store_q;
  logic            unsigned_q;
  logic [1:0]      cnt_q;
  logic [1:0]      last_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] assembled;
  logic [XLEN-1:0] load_ext;
  logic [2:0]      req_bytes;
  logic            req_bad;

  always_comb begin
    req_bytes = size_bytes(size_e'(req_size));
    req_bad   = (req_bytes == 3'd0);
`ifdef MISALIGN_TRAP_EN
    if (misaligned(size_e'(req_size), req_addr[1:0])) req_bad = 1'b1;
`endif
  end

  // The byte arriving this cycle lands in its lane so the final byte can be
  // extended and registered in the same edge that ends the access.
  always_comb begin
    assembled = data_q;
    assembled[DATA_W*cnt_q +: DATA_W] = mem_rdata;
  end

  lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
    .word        (assembled),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .ext         (load_ext)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // reader in this edge sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      size_q     <= SZ_BYTE;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      wdata_q    <= '0;
      data_q     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            size_q     <= size_e'(req_size);
            store_q    <= req_store;
            unsigned_q <= req_unsigned;
            cnt_q      <= 2'd0;
            last_q     <= req_bytes[1:0] - 2'd1;
            wdata_q    <= req_wdata;
            data_q     <= '0;
            req_ready  <= 1'b0;
            if (req_bad) begin
              // Rejected requests skip memory entirely; addresses keep their old value.
              state_q    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q   <= ST_ACCESS;
              mem_we    <= req_store;
              mem_raddr <= req_addr;
              mem_waddr <= req_addr;
              mem_wdata <= req_wdata[DATA_W-1:0];
            end
          end
        end

        ST_ACCESS: begin
          if (!store_q) data_q <= assembled;
          if (cnt_q == last_q) begin
            state_q    <= ST_RESP;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= store_q ? '0 : load_ext;
          end else begin
            // Addresses wrap naturally at the top of the ADDR_W-bit space.
            cnt_q     <= cnt_q + 2'd1;
            mem_raddr <= mem_raddr + ADDR_STEP;
            mem_waddr <= mem_waddr + ADDR_STEP;
            mem_wdata <= wdata_q[2*DATA_W-1:DATA_W];
            wdata_q   <= wdata_q >> DATA_W;
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            state_q    <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
